// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// uart_tx_arbiter : packet-level round-robin arbiter onto one UART TX FIFO
//   write port. Optional burst cap: define UART_ARB_BURST_LIMIT_EN.
// Revision: 1.0
// ============================================================================
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [NUM_REQ-1:0]                           req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]                req_data,
  input  logic [NUM_REQ-1:0]                           req_last,
  output logic [NUM_REQ-1:0]                           req_ready,
  output logic                                         fifo_w_en,
  output logic [DATA_WIDTH-1:0]                        fifo_w_data,
  input  logic                                         fifo_full,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] gnt_id,
  output logic                                         busy
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [GW-1:0]         r_gnt_id;
  logic [GW-1:0]         r_last_gnt;
  logic [GW-1:0]         w_sel;
  logic                  w_any;
  logic                  w_beat;
  logic                  w_end;
  logic                  w_limit;
  logic [DATA_WIDTH-1:0] w_data_arr [NUM_REQ];

  generate
    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || DATA_WIDTH < 1) begin : g_param_check
      $error("uart_tx_arbiter: parameter out of range");
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Scan from farthest to nearest so the nearest valid index after
  // r_last_gnt is the one left standing.
  always_comb begin
    int            w_idx;
    logic [GW-1:0] w_idx_n;
    w_sel   = r_last_gnt;
    w_any   = 1'b0;
    w_idx   = 0;
    w_idx_n = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx   = (int'(r_last_gnt) + k) % NUM_REQ;
      w_idx_n = GW'(w_idx);
      if (req_valid[w_idx_n]) begin
        w_sel = w_idx_n;
        w_any = 1'b1;
      end
    end
  end

`ifdef UART_ARB_BURST_LIMIT_EN
  localparam int            CW          = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] c_LAST_BEAT = CW'(MAX_BURST - 1);

  logic [CW-1:0] r_beat_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      r_beat_cnt <= '0;
    end else if (w_beat) begin
      r_beat_cnt <= r_beat_cnt + CW'(1);
    end
  end

  assign w_limit = (r_beat_cnt == c_LAST_BEAT);
`else
  assign w_limit = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    fifo_w_en   = 1'b0;
    fifo_w_data = '0;
    w_beat      = 1'b0;
    w_end       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_BURST;
        end
      end
      S_BURST: begin
        req_ready[r_gnt_id] = !fifo_full;
        w_beat              = req_valid[r_gnt_id] && !fifo_full;
        fifo_w_en           = w_beat;
        fifo_w_data         = w_data_arr[r_gnt_id];
        w_end               = w_beat && (req_last[r_gnt_id] || w_limit);
        if (w_end) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_gnt_id   <= '0;
      r_last_gnt <= GW'(NUM_REQ - 1);
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_any) begin
        r_gnt_id <= w_sel;
      end
      if (w_end) begin
        r_last_gnt <= r_gnt_id;
      end
    end
  end

  assign busy   = (r_state == S_BURST);
  assign gnt_id = r_gnt_id;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_arbiter : directed self-checking bench for uart_tx_arbiter.
// Revision: 1.0
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int GW = 2;
`ifdef UART_ARB_BURST_LIMIT_EN
  localparam int MB = 4;
`else
  localparam int MB = 16;
`endif

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*DW-1:0] req_data  = '0;
  logic [NR-1:0]    req_last  = '0;
  logic [NR-1:0]    req_ready;
  logic             fifo_w_en;
  logic [DW-1:0]    fifo_w_data;
  logic             fifo_full = 1'b0;
  logic [GW-1:0]    gnt_id;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-requester byte sources: {last, data}; FIFO write capture.
  logic [8:0]    srcq [NR][$];
  logic [7:0]    got  [$];
  logic [7:0]    exp_q[$];
  logic [NR-1:0] pend_pop = '0;

  uart_tx_arbiter #(
    .NUM_REQ   (NR),
    .DATA_WIDTH(DW),
    .MAX_BURST (MB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_w_en  (fifo_w_en),
    .fifo_w_data(fifo_w_data),
    .fifo_full  (fifo_full),
    .gnt_id     (gnt_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      pend_pop = req_valid & req_ready;
      if (fifo_w_en) got.push_back(fifo_w_data);
    end else begin
      pend_pop = '0;
    end
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NR; i++) begin
      if (pend_pop[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
      if (srcq[i].size() > 0) begin
        req_valid[i]         = 1'b1;
        req_last[i]          = srcq[i][0][8];
        req_data[i*DW +: DW] = srcq[i][0][7:0];
      end else begin
        req_valid[i]         = 1'b0;
        req_last[i]          = 1'b0;
        req_data[i*DW +: DW] = '0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_got(input string tag);
    chk({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("%s_b%0d", tag, i), (i < got.size()) ? 32'(got[i]) : 32'hxxxx_xxxx,
          32'(exp_q[i]));
    end
  endtask

  task automatic wait_got(input int n);
    int c;
    c = 0;
    while (got.size() < n && c < 100) begin
      tick();
      c++;
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NR; i++) srcq[i].delete();
    tick();
    tick();
    rst_n = 1'b1;
    got.delete();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"},  32'(busy),      32'd0);
    chk({tag, "_gnt"},   32'(gnt_id),    32'd0);
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_wen"},   32'(fifo_w_en), 32'd0);
  endtask

  initial begin
    // Reset, then 20 idle cycles with nothing requested.
    tick();
    tick();
    chk_reset_outs("rst");
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_wen", 32'(fifo_w_en), 32'd0);
    end
    chk("idle_writes", 32'(got.size()), 32'd0);

    // Single requester 2, three bytes.
    srcq[2].push_back({1'b0, 8'h41});
    srcq[2].push_back({1'b0, 8'h42});
    srcq[2].push_back({1'b1, 8'h43});
    tick();
    chk("r2_pre_busy", 32'(busy), 32'd0);
    chk("r2_pre_wen",  32'(fifo_w_en), 32'd0);
    tick();
    chk("r2_gnt",   32'(gnt_id),      32'd2);
    chk("r2_busy0", 32'(busy),        32'd1);
    chk("r2_ready", 32'(req_ready),   32'b0100);
    chk("r2_wen0",  32'(fifo_w_en),   32'd1);
    chk("r2_d0",    32'(fifo_w_data), 32'h41);
    tick();
    chk("r2_busy1", 32'(busy),        32'd1);
    chk("r2_d1",    32'(fifo_w_data), 32'h42);
    tick();
    chk("r2_busy2", 32'(busy),        32'd1);
    chk("r2_d2",    32'(fifo_w_data), 32'h43);
    tick();
    chk("r2_busy3", 32'(busy),        32'd0);
    chk("r2_wen3",  32'(fifo_w_en),   32'd0);
    exp_q = '{8'h41, 8'h42, 8'h43};
    chk_got("r2_seq");

    // Three concurrent requesters, then a late second packet from req0.
    pulse_reset();
    srcq[0].push_back({1'b0, 8'hA0});
    srcq[0].push_back({1'b1, 8'hA1});
    srcq[1].push_back({1'b0, 8'hB0});
    srcq[1].push_back({1'b1, 8'hB1});
    srcq[3].push_back({1'b0, 8'hD0});
    srcq[3].push_back({1'b1, 8'hD1});
    wait_got(2);
    srcq[0].push_back({1'b0, 8'hA2});
    srcq[0].push_back({1'b1, 8'hA3});
    wait_got(8);
    tick();
    tick();
    exp_q = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hD0, 8'hD1, 8'hA2, 8'hA3};
    chk_got("rr_seq");
    got.delete();

    // FIFO full for 5 cycles after the first byte.
    srcq[2].push_back({1'b0, 8'h55});
    srcq[2].push_back({1'b1, 8'h66});
    tick();
    tick();
    chk("full_d0", 32'(fifo_w_data), 32'h55);
    tick();
    fifo_full = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("full_wen",   32'(fifo_w_en), 32'd0);
      chk("full_ready", 32'(req_ready), 32'd0);
      chk("full_busy",  32'(busy),      32'd1);
      tick();
    end
    fifo_full = 1'b0;
    #1;
    chk("resume_wen", 32'(fifo_w_en),   32'd1);
    chk("resume_d",   32'(fifo_w_data), 32'h66);
    tick();
    tick();
    chk("full_done_busy", 32'(busy), 32'd0);
    exp_q = '{8'h55, 8'h66};
    chk_got("full_seq");
    got.delete();

    // Reset in the middle of a 4-byte burst from requester 3.
    srcq[3].push_back({1'b0, 8'h10});
    srcq[3].push_back({1'b0, 8'h11});
    srcq[3].push_back({1'b0, 8'h12});
    srcq[3].push_back({1'b1, 8'h13});
    tick();
    tick();
    chk("mid_gnt", 32'(gnt_id), 32'd3);
    tick();
    tick();
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("midrst");
    pulse_reset();
    srcq[0].push_back({1'b1, 8'h20});
    srcq[3].push_back({1'b1, 8'h30});
    tick();
    tick();
    chk("post_gnt",  32'(gnt_id),      32'd0);
    chk("post_d",    32'(fifo_w_data), 32'h20);
    tick();
    chk("post_busy", 32'(busy),        32'd0);
    wait_got(2);
    exp_q = '{8'h20, 8'h30};
    chk_got("post_seq");

`ifdef UART_ARB_BURST_LIMIT_EN
    // Burst cap of 4 splits requester 1's 6-byte packet around req2.
    pulse_reset();
    for (int i = 0; i < 6; i++) srcq[1].push_back({(i == 5), 8'(8'h60 + i)});
    srcq[2].push_back({1'b0, 8'h70});
    srcq[2].push_back({1'b1, 8'h71});
    wait_got(8);
    exp_q = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h70, 8'h71, 8'h64, 8'h65};
    chk_got("limit_seq");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
